// File: rtl/decode_pkg.sv
// Shared constants for the decode stage slice:
// default widths, instruction field positions, control bits.
package decode_pkg;

  localparam int INSTR_W  = 20;
  localparam int DATA_W   = 19;
  localparam int PC_W     = 15;
  localparam int RA_W     = 5;
  localparam int NUM_REGS = 19;
  localparam int CTRL_W   = 10;
  localparam int CNT_W    = 16;

  localparam int RD_LSB  = 5;
  localparam int RS1_LSB = 10;
  localparam int RS2_LSB = 15;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_JUMP       = 2;
  localparam int CTRL_BRANCH_LSB = 3;
  localparam int CTRL_BRANCH_MSB = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_RESULT_SRC = 6;
  localparam int CTRL_ALU_LSB    = 7;
  localparam int CTRL_ALU_MSB    = 9;

  localparam int LOAD_BIT = CTRL_RESULT_SRC;

endpackage

// File: rtl/decode_regfile.sv
// Register file: 2 read / 1 write, hard zero register,
// out-of-range addresses read 0, write-first bypass.
module decode_regfile #(
  parameter int DATA_W   = 19,
  parameter int RA_W     = 5,
  parameter int NUM_REGS = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic              wr_ok;

  // write is effective only for an implemented, non-zero register
  always_comb begin
    wr_ok = 1'b0;
    for (int i = 1; i < NUM_REGS; i++)
      if (wa == RA_W'(i))
        wr_ok = we;
  end

  // storage update, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wa == RA_W'(i))
          regs[i] <= wd;
    end
  end

  // read mux with same-cycle writeback forwarding
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ra1 == RA_W'(i))
        rd1 = regs[i];
      if (ra2 == RA_W'(i))
        rd2 = regs[i];
    end
    if (wr_ok && wa == ra1)
      rd1 = wd;
    if (wr_ok && wa == ra2)
      rd2 = wd;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register read, load-use detection,
// ID/EX register with flush/hold/bubble and bubble counter.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int INSTR_W  = decode_pkg::INSTR_W,
  parameter int DATA_W   = decode_pkg::DATA_W,
  parameter int PC_W     = decode_pkg::PC_W,
  parameter int RA_W     = decode_pkg::RA_W,
  parameter int NUM_REGS = decode_pkg::NUM_REGS,
  parameter int CTRL_W   = decode_pkg::CTRL_W,
  parameter int LOAD_BIT = decode_pkg::LOAD_BIT,
  parameter int RD_LSB   = decode_pkg::RD_LSB,
  parameter int RS1_LSB  = decode_pkg::RS1_LSB,
  parameter int RS2_LSB  = decode_pkg::RS2_LSB,
  parameter int CNT_W    = decode_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc_d,
  input  logic               valid_d,
  input  logic [CTRL_W-1:0]  ctrl_d,
  input  logic [DATA_W-1:0]  imm_d,
  input  logic               reg_write_w,
  input  logic [RA_W-1:0]    rd_w,
  input  logic [DATA_W-1:0]  result_w,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic [CTRL_W-1:0]  ctrl_e,
  output logic [DATA_W-1:0]  rd1_e,
  output logic [DATA_W-1:0]  rd2_e,
  output logic [DATA_W-1:0]  imm_e,
  output logic [PC_W-1:0]    pc_e,
  output logic [RA_W-1:0]    rd_e,
  output logic [RA_W-1:0]    rs1_e,
  output logic [RA_W-1:0]    rs2_e,
  output logic               valid_e,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   bubble_count
);

  logic [RA_W-1:0]   rs1_d;
  logic [RA_W-1:0]   rs2_d;
  logic [RA_W-1:0]   rd_d;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;
  logic              bubble;
  logic              unused_instr;

  assign rs1_d = instr_d[RS1_LSB +: RA_W];
  assign rs2_d = instr_d[RS2_LSB +: RA_W];
  assign rd_d  = instr_d[RD_LSB +: RA_W];

  assign unused_instr = ^instr_d;

  decode_regfile #(
    .DATA_W   (DATA_W),
    .RA_W     (RA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1_d),
    .ra2   (rs2_d),
    .rd1   (rd1_d),
    .rd2   (rd2_d),
    .we    (reg_write_w),
    .wa    (rd_w),
    .wd    (result_w)
  );

  // both source fields compared whatever the format
  assign load_use_stall = valid_d & valid_e
                        & ctrl_e[LOAD_BIT]
                        & (rd_e != '0)
                        & ((rd_e == rs1_d) | (rd_e == rs2_d));

  // a counted bubble only when neither flush nor hold wins
  assign bubble = load_use_stall & ~flush_i & ~hold_i;

  // ID/EX register: flush > hold > bubble > capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush_i || bubble) begin
      ctrl_e  <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      pc_e    <= '0;
      rd_e    <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      valid_e <= 1'b0;
    end else if (!hold_i) begin
      ctrl_e  <= valid_d ? ctrl_d : '0;
      rd1_e   <= rd1_d;
      rd2_e   <= rd2_d;
      imm_e   <= imm_d;
      pc_e    <= pc_d;
      rd_e    <= rd_d;
      rs1_e   <= rs1_d;
      rs2_e   <= rs2_d;
      valid_e <= valid_d;
    end
  end

  // saturating count of load-use bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bubble_count <= '0;
    else if (bubble && !(&bubble_count))
      bubble_count <= bubble_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised bench for decode_stage_pipe against
// a behavioural model of the decode/ID-EX rules.
module tb_decode_stage_pipe;

  localparam int INSTR_W  = 20;
  localparam int DATA_W   = 19;
  localparam int PC_W     = 15;
  localparam int RA_W     = 5;
  localparam int NUM_REGS = 19;
  localparam int CTRL_W   = 10;
  localparam int LOAD_BIT = 6;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;

  logic               clk;
  logic               reset;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    pc_d;
  logic               valid_d;
  logic [CTRL_W-1:0]  ctrl_d;
  logic [DATA_W-1:0]  imm_d;
  logic               reg_write_w;
  logic [RA_W-1:0]    rd_w;
  logic [DATA_W-1:0]  result_w;
  logic               hold_i;
  logic               flush_i;
  logic [CTRL_W-1:0]  ctrl_e;
  logic [DATA_W-1:0]  rd1_e;
  logic [DATA_W-1:0]  rd2_e;
  logic [DATA_W-1:0]  imm_e;
  logic [PC_W-1:0]    pc_e;
  logic [RA_W-1:0]    rd_e;
  logic [RA_W-1:0]    rs1_e;
  logic [RA_W-1:0]    rs2_e;
  logic               valid_e;
  logic               load_use_stall;
  logic [CNT_W-1:0]   bubble_count;

  decode_stage_pipe #(
    .INSTR_W  (INSTR_W),
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .RA_W     (RA_W),
    .NUM_REGS (NUM_REGS),
    .CTRL_W   (CTRL_W),
    .LOAD_BIT (LOAD_BIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .valid_d        (valid_d),
    .ctrl_d         (ctrl_d),
    .imm_d          (imm_d),
    .reg_write_w    (reg_write_w),
    .rd_w           (rd_w),
    .result_w       (result_w),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .ctrl_e         (ctrl_e),
    .rd1_e          (rd1_e),
    .rd2_e          (rd2_e),
    .imm_e          (imm_e),
    .pc_e           (pc_e),
    .rd_e           (rd_e),
    .rs1_e          (rs1_e),
    .rs2_e          (rs2_e),
    .valid_e        (valid_e),
    .load_use_stall (load_use_stall),
    .bubble_count   (bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // behavioural model state
  int m_regs [32];
  int m_valid, m_ctrl, m_rd1, m_rd2;
  int m_imm, m_pc, m_rd, m_rs1, m_rs2;
  int m_cnt;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0;
    m_imm = 0; m_pc = 0; m_rd = 0; m_rs1 = 0;
    m_rs2 = 0; m_cnt = 0;
  endtask

  function automatic int f_rs1();
    return int'(instr_d[14:10]);
  endfunction

  function automatic int f_rs2();
    return int'(instr_d[19:15]);
  endfunction

  function automatic int f_rd();
    return int'(instr_d[9:5]);
  endfunction

  function automatic bit w_ok();
    return reg_write_w && rd_w != 0 &&
           int'(rd_w) < NUM_REGS;
  endfunction

  function automatic int m_read(input int a);
    if (a == 0 || a >= NUM_REGS) return 0;
    if (w_ok() && int'(rd_w) == a)
      return int'(result_w);
    return m_regs[a];
  endfunction

  function automatic bit m_stall();
    return valid_d && m_valid != 0 &&
           m_ctrl[LOAD_BIT] && m_rd != 0 &&
           (m_rd == f_rs1() || m_rd == f_rs2());
  endfunction

  task automatic m_clear();
    m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0;
    m_imm = 0; m_pc = 0; m_rd = 0; m_rs1 = 0;
    m_rs2 = 0;
  endtask

  task automatic cmp_outputs();
    chk("valid_e", 32'(valid_e), m_valid);
    chk("ctrl_e", 32'(ctrl_e), m_ctrl);
    chk("rd1_e", 32'(rd1_e), m_rd1);
    chk("rd2_e", 32'(rd2_e), m_rd2);
    chk("imm_e", 32'(imm_e), m_imm);
    chk("pc_e", 32'(pc_e), m_pc);
    chk("rd_e", 32'(rd_e), m_rd);
    chk("rs1_e", 32'(rs1_e), m_rs1);
    chk("rs2_e", 32'(rs2_e), m_rs2);
    chk("bubble_count", 32'(bubble_count), m_cnt);
  endtask

  // one clock: check stall, advance model, check E outputs
  task automatic tick();
    bit st;
    int r1, r2;
    #1;
    st = m_stall();
    chk("load_use_stall", 32'(load_use_stall), 32'(st));
    r1 = m_read(f_rs1());
    r2 = m_read(f_rs2());
    @(posedge clk);
    if (flush_i) begin
      m_clear();
    end else if (hold_i) begin
    end else if (st) begin
      m_clear();
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = int'(valid_d);
      m_ctrl  = valid_d ? int'(ctrl_d) : 0;
      m_rd1 = r1; m_rd2 = r2;
      m_imm = int'(imm_d); m_pc = int'(pc_d);
      m_rd = f_rd(); m_rs1 = f_rs1(); m_rs2 = f_rs2();
    end
    if (w_ok()) m_regs[rd_w] = int'(result_w);
    #1;
    cmp_outputs();
  endtask

  task automatic set_d(input bit v, input int rd,
                       input int rs1, input int rs2,
                       input int ctrl);
    logic [RA_W-1:0] a;
    instr_d = INSTR_W'($urandom);
    a = RA_W'(rd);  instr_d[9:5]   = a;
    a = RA_W'(rs1); instr_d[14:10] = a;
    a = RA_W'(rs2); instr_d[19:15] = a;
    valid_d = v;
    ctrl_d  = CTRL_W'(ctrl);
    imm_d   = DATA_W'($urandom);
    pc_d    = PC_W'($urandom);
  endtask

  int pick [8] = '{0, 1, 2, 3, 4, 18, 19, 31};
  logic [PC_W-1:0] held_pc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    hold_i = 0; flush_i = 0;
    reg_write_w = 0; rd_w = '0; result_w = '0;
    set_d(0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    m_reset();
    #10;
    cmp_outputs();
    chk("rst_stall", 32'(load_use_stall), 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // write then read from array
    reg_write_w = 1; rd_w = 3; result_w = 19'h1234;
    set_d(0, 0, 0, 0, 0);
    tick();
    reg_write_w = 0;
    set_d(1, 9, 3, 0, 0);
    tick();
    chk("wr_rd", 32'(rd1_e), 32'h1234);

    // same-cycle bypass
    reg_write_w = 1; rd_w = 7; result_w = 19'h7ABCD;
    set_d(1, 1, 0, 7, 0);
    tick();
    chk("bypass", 32'(rd2_e), 32'h7ABCD);
    reg_write_w = 0;

    // load-use pair
    set_d(1, 4, 0, 0, 'h040);
    tick();
    set_d(1, 5, 4, 1, 0);
    #1 chk("lu_stall", 32'(load_use_stall), 1);
    tick();
    chk("lu_bubble", 32'(valid_e), 0);
    chk("lu_cnt", 32'(bubble_count), 1);
    #1 chk("lu_clear", 32'(load_use_stall), 0);
    tick();
    chk("lu_cap", 32'(valid_e), 1);
    chk("lu_rs1", 32'(rs1_e), 4);

    // zero register
    reg_write_w = 1; rd_w = 0; result_w = 19'h55;
    set_d(1, 0, 0, 0, 'h040);
    tick();
    reg_write_w = 0;
    set_d(1, 2, 0, 0, 0);
    #1 chk("zero_nostall", 32'(load_use_stall), 0);
    tick();
    chk("zero_rd", 32'(rd1_e), 0);

    // flush beats hazard
    set_d(1, 4, 0, 0, 'h040);
    tick();
    set_d(1, 5, 4, 4, 0);
    flush_i = 1;
    tick();
    flush_i = 0;
    chk("flush_valid", 32'(valid_e), 0);
    chk("flush_cnt", 32'(bubble_count), 1);

    // hold keeps ID/EX
    set_d(1, 6, 2, 3, 'h2A1);
    held_pc = pc_d;
    tick();
    hold_i = 1;
    for (int k = 0; k < 3; k++) begin
      set_d(1, k + 1, k, k + 2, int'($urandom) & 'h3BF);
      tick();
      chk("hold_pc", 32'(pc_e), 32'(held_pc));
    end
    hold_i = 0;

    // hold with a pending stall
    set_d(1, 3, 0, 0, 'h040);
    tick();
    set_d(1, 8, 1, 3, 0);
    hold_i = 1;
    tick();
    tick();
    chk("hold_st", 32'(load_use_stall), 1);
    hold_i = 0;
    tick();
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_d($urandom_range(0, 99) < 85,
            pick[$urandom_range(0, 7)],
            pick[$urandom_range(0, 7)],
            pick[$urandom_range(0, 7)],
            int'($urandom) & 'h3BF |
            ($urandom_range(0, 1) ? 'h040 : 0));
      reg_write_w = $urandom_range(0, 1);
      rd_w = RA_W'(pick[$urandom_range(0, 7)]);
      result_w = DATA_W'($urandom);
      hold_i = $urandom_range(0, 99) < 15;
      flush_i = $urandom_range(0, 99) < 10;
      tick();
    end
    hold_i = 0; flush_i = 0; reg_write_w = 0;

    // drive counter into saturation
    for (int n = 0; n < 20; n++) begin
      set_d(1, 2, 0, 0, 'h040);
      tick();
      set_d(1, 1, 2, 0, 0);
      tick();
    end
    chk("cnt_sat", 32'(bubble_count), CNT_MAX);

    // async reset in the middle of a stall
    reg_write_w = 1; rd_w = 3; result_w = 19'h1234;
    set_d(1, 4, 0, 0, 'h040);
    tick();
    reg_write_w = 0;
    set_d(1, 5, 4, 0, 0);
    #1 chk("pre_rst_stall", 32'(load_use_stall), 1);
    reset = 1'b0;
    #1;
    m_reset();
    chk("arst_stall", 32'(load_use_stall), 0);
    chk("arst_valid", 32'(valid_e), 0);
    chk("arst_cnt", 32'(bubble_count), 0);
    cmp_outputs();
    #2 reset = 1'b1;
    set_d(1, 1, 3, 7, 0);
    tick();
    chk("arst_r3", 32'(rd1_e), 0);
    chk("arst_r7", 32'(rd2_e), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
